fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch and sequencing stage directly upstream of the control unit.
- Holds the PC and addresses the synchronous instruction memory. Latches the instruction register (IR) and presents Opcode = IR[31:24] to the control unit.
- Drives Inibe to blank control signals while no valid instruction is in execute.
- Applies the branch, halt and IN-wait decisions that the control unit returns. Issues a one-cycle Commit strobe that the datapath uses to gate register, CPSR and memory writes.

Parameters:
- ADDR_W, 10, PC / instruction address width.
- INSTR_W, 32, instruction width (Opcode is always the top 8 bits).
- DEBOUNCE_CYCLES, 4, consecutive synchronized-high cycles needed to accept the confirm button (≥1).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high.
- EndInstr  output  ADDR_W  instruction memory address (= PC).
- InstrMem  input  INSTR_W  instruction memory read data, valid one cycle after the address.
- Instrucao  output  INSTR_W  IR contents.
- Opcode  output  8  IR[INSTR_W-1:INSTR_W-8], to the control unit.
- Inibe  output  1  1 = control unit forced to idle.
- CTRLDesvio  input  2  00 PC+1, 01 immediate target, 10 register target, 11 treated as 00.
- AlvoImediato  input  ADDR_W  branch target, immediate.
- AlvoReg  input  ADDR_W  branch target, register (BX).
- CTRLHalt  input  1  halt request.
- CTRLCLK  input  1  IN instruction: wait for confirm.
- BotaoConfirma  input  1  asynchronous confirm button, active-high.
- PCMais1  output  ADDR_W  PC+1 (link value for BL).
- Commit  output  1  one-cycle write-enable qualifier.
- Halted  output  1  processor halted.

Behaviour:
- Reset (synchronous, Reset=1 at a rising edge; applies in every state, including WAIT_IN mid-wait):
  - PC=0, IR=0, state=FETCH.
  - Inibe=1, Commit=0, Halted=0.
  - Synchronizer flops, debounce counter and debounced level all cleared.
- States: FETCH, LOAD, EXEC, WAIT_IN, HALT.
- FETCH:
  - EndInstr=PC, Inibe=1, Commit=0.
  - Next state: LOAD.
- LOAD:
  - IR <= InstrMem at the edge.
  - Inibe=1, Commit=0.
  - Next state: EXEC.
- EXEC:
  - Inibe=0; control inputs are sampled this cycle.
  - Priority: CTRLHalt > CTRLCLK > normal.
  - CTRLHalt=1:
    - Commit=0, PC unchanged.
    - Next state: HALT.
  - Else CTRLCLK=1:
    - Commit=0.
    - Next state: WAIT_IN.
  - Else:
    - Commit=1.
    - PC <= PC+1, AlvoImediato or AlvoReg per CTRLDesvio.
    - Next state: FETCH.
- WAIT_IN:
  - Inibe=0 (control unit keeps CTRLCLK/LEDIN asserted), Commit=0.
  - On the first cycle with a debounced rising edge: Commit=1 for exactly that cycle, PC <= PC+1, next state FETCH.
  - A button held high on entry is not accepted; a release and a fresh press are required.
- HALT:
  - Inibe=1, Halted=1, Commit=0, PC frozen.
  - Only Reset exits this state.
- Instruction timing: 3 cycles per instruction, excluding IN wait.
- PC arithmetic: modulo 2^ADDR_W; PC = 2^ADDR_W-1 with a sequential step wraps to 0.
- PCMais1 is combinational PC+1, same wrap rule.
- Confirm button path:
  - 2-flop synchronizer.
  - Counter increments while the synchronized value is 1 and clears to 0 when it is 0.
  - Debounced level sets when the counter reaches DEBOUNCE_CYCLES (counter saturates there) and clears when the synchronized value is 0.
  - A rising edge is the debounced level going 0→1.
  - The button path runs in every state; only WAIT_IN consumes the edge. Edges arriving in other states are discarded.
- Branch selection: CTRLDesvio=11 behaves exactly as 00.

Test Plan:
- Reset, memory holding ADD, SUB, ADD at addresses 0–2 → EndInstr 0, 1, 2 at 3-cycle spacing; Inibe pattern 1,1,0 per instruction; Commit high only in each EXEC cycle.
- EXEC with CTRLDesvio=01, AlvoImediato=0x123 → next EndInstr=0x123. Then CTRLDesvio=10, AlvoReg=0x005 → next 0x005. Then CTRLDesvio=11 at PC=0x005 → next 0x006; PCMais1=0x006 during that EXEC.
- PC=0x3FF with sequential step → PC=0x000, no stall.
- CTRLCLK=1 in EXEC with the button bouncing 1,0,1,0 then held high → Commit stays 0 during bounce; exactly one Commit pulse 2+DEBOUNCE_CYCLES cycles after the stable-high start, then FETCH with PC+1. Button held high on WAIT_IN entry → no Commit until released and re-pressed.
- CTRLHalt=1 together with CTRLCLK=1 → HALT takes priority; Halted=1, Inibe=1, EndInstr frozen for 20+ cycles; button presses ignored.
- Reset asserted mid-WAIT_IN and mid-HALT → next cycle PC=0, state FETCH, Halted=0, Commit=0, debounce state cleared.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch and sequencing stage ahead of the control unit.
//
// Holds the PC, addresses the synchronous instruction memory, latches the IR
// and hands the opcode to the control unit. It then applies the branch, halt
// and IN-wait decisions that the control unit returns. Each instruction takes
// three cycles: FETCH (address out), LOAD (IR captured) and EXEC (control
// unit active). An IN instruction adds WAIT_IN, which lasts until a debounced
// press of the confirm button.
//
// Ports:
//   Clock, Reset   rising-edge clock, synchronous active-high reset
//   EndInstr       instruction memory address (= PC)
//   InstrMem       instruction memory read data (one cycle after address)
//   Instrucao      IR contents
//   Opcode         IR top byte, to the control unit
//   Inibe          1 = control unit forced idle (no valid instruction in EXEC)
//   CTRLDesvio     00/11 PC+1, 01 AlvoImediato, 10 AlvoReg
//   AlvoImediato   immediate branch target
//   AlvoReg        register branch target (BX)
//   CTRLHalt       halt request (highest priority in EXEC)
//   CTRLCLK        IN instruction: wait for confirm button
//   BotaoConfirma  asynchronous confirm button, active-high
//   PCMais1        PC+1 (link value), wraps modulo 2^ADDR_W
//   Commit         one-cycle write qualifier for register/CPSR/memory writes
//   Halted         processor halted (only Reset leaves this)
module fetch_sequencer #(
  parameter int ADDR_W          = 10,
  parameter int INSTR_W         = 32,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  EndInstr,
  input  logic [INSTR_W-1:0] InstrMem,
  output logic [INSTR_W-1:0] Instrucao,
  output logic [7:0]         Opcode,
  output logic               Inibe,
  input  logic [1:0]         CTRLDesvio,
  input  logic [ADDR_W-1:0]  AlvoImediato,
  input  logic [ADDR_W-1:0]  AlvoReg,
  input  logic               CTRLHalt,
  input  logic               CTRLCLK,
  input  logic               BotaoConfirma,
  output logic [ADDR_W-1:0]  PCMais1,
  output logic               Commit,
  output logic               Halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_WAIT_IN,
    S_HALT
  } state_t;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   pc, pc_nx, pc_inc;
  logic [INSTR_W-1:0]  ir;
  logic                load_ir;

  // Confirm button: 2-flop synchronizer, saturating debounce counter,
  // debounced level and its delayed copy for edge detection.
  logic                sync1, sync2;
  logic [CNT_W-1:0]    deb_cnt;
  logic                deb_lvl, deb_lvl_q;
  logic                deb_rise;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_cnt   <= '0;
      deb_lvl   <= 1'b0;
      deb_lvl_q <= 1'b0;
    end else begin
      sync1     <= BotaoConfirma;
      sync2     <= sync1;
      deb_lvl_q <= deb_lvl;
      if (!sync2) begin
        deb_cnt <= '0;
        deb_lvl <= 1'b0;
      end else if (deb_cnt != CNT_MAX) begin
        deb_cnt <= deb_cnt + CNT_ONE;
        // Level goes high on the same edge the counter reaches the limit.
        if (deb_cnt == CNT_MAX - CNT_ONE) deb_lvl <= 1'b1;
      end
    end
  end

  // Edge is produced in every state; only WAIT_IN acts on it, so a press
  // completed elsewhere (or a button already held on entry) is lost.
  assign deb_rise = deb_lvl & ~deb_lvl_q;

  assign pc_inc = pc + ADDR_W'(1);

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    Inibe    = 1'b1;
    Commit   = 1'b0;
    load_ir  = 1'b0;
    case (state)
      S_FETCH: state_nx = S_LOAD;
      S_LOAD: begin
        load_ir  = 1'b1;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        Inibe = 1'b0;
        if (CTRLHalt) begin
          state_nx = S_HALT;
        end else if (CTRLCLK) begin
          state_nx = S_WAIT_IN;
        end else begin
          Commit   = 1'b1;
          state_nx = S_FETCH;
          case (CTRLDesvio)
            2'b01:   pc_nx = AlvoImediato;
            2'b10:   pc_nx = AlvoReg;
            default: pc_nx = pc_inc;
          endcase
        end
      end
      S_WAIT_IN: begin
        Inibe = 1'b0;
        if (deb_rise) begin
          Commit   = 1'b1;
          pc_nx    = pc_inc;
          state_nx = S_FETCH;
        end
      end
      S_HALT: begin
        state_nx = S_HALT;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (load_ir) ir <= InstrMem;
    end
  end

  assign EndInstr  = pc;
  assign PCMais1   = pc_inc;
  assign Instrucao = ir;
  assign Opcode    = ir[INSTR_W-1:INSTR_W-8];
  assign Halted    = (state == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: random memory image and random branch traffic
// checked against a PC/phase reference model, plus directed IN-wait, halt,
// wrap and mid-state reset scenarios.
module tb_fetch_sequencer;
  localparam int AW  = 10;
  localparam int IW  = 32;
  localparam int DB  = 4;
  localparam int NPC = 1 << AW;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [AW-1:0] EndInstr;
  logic [IW-1:0] InstrMem;
  logic [IW-1:0] Instrucao;
  logic [7:0]    Opcode;
  logic          Inibe;
  logic [1:0]    CTRLDesvio;
  logic [AW-1:0] AlvoImediato;
  logic [AW-1:0] AlvoReg;
  logic          CTRLHalt;
  logic          CTRLCLK;
  logic          BotaoConfirma;
  logic [AW-1:0] PCMais1;
  logic          Commit;
  logic          Halted;

  fetch_sequencer #(.ADDR_W(AW), .INSTR_W(IW), .DEBOUNCE_CYCLES(DB)) dut (
    .Clock(Clock), .Reset(Reset), .EndInstr(EndInstr), .InstrMem(InstrMem),
    .Instrucao(Instrucao), .Opcode(Opcode), .Inibe(Inibe),
    .CTRLDesvio(CTRLDesvio), .AlvoImediato(AlvoImediato), .AlvoReg(AlvoReg),
    .CTRLHalt(CTRLHalt), .CTRLCLK(CTRLCLK), .BotaoConfirma(BotaoConfirma),
    .PCMais1(PCMais1), .Commit(Commit), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  // Synchronous instruction memory
  logic [IW-1:0] mem [NPC];
  always @(posedge Clock) InstrMem <= mem[EndInstr];

  int checks = 0;
  int errors = 0;
  int m_pc;   // reference PC

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nxt(input int pc);
    return (pc + 1) % NPC;
  endfunction

  // Entered in a FETCH cycle; leaves in the cycle after EXEC.
  task automatic run_instr(input int desvio, input int imm, input int rg,
                           input bit halt, input bit clkin);
    logic [IW-1:0] word;
    word = mem[m_pc];
    chk("fetch_addr", EndInstr, m_pc);
    chk("fetch_inibe", Inibe, 1);
    chk("fetch_commit", Commit, 0);
    tick();
    chk("load_addr", EndInstr, m_pc);
    chk("load_inibe", Inibe, 1);
    chk("load_commit", Commit, 0);
    tick();
    CTRLDesvio = 2'(desvio); AlvoImediato = AW'(imm); AlvoReg = AW'(rg);
    CTRLHalt = halt; CTRLCLK = clkin;
    #1;
    chk("exec_inibe", Inibe, 0);
    chk("exec_ir", Instrucao, word);
    chk("exec_opcode", Opcode, word[31:24]);
    chk("exec_pcmais1", PCMais1, nxt(m_pc));
    chk("exec_commit", Commit, (halt || clkin) ? 0 : 1);
    tick();
    if (!halt && !clkin)
      m_pc = (desvio == 1) ? imm : (desvio == 2) ? rg : nxt(m_pc);
  endtask

  // Button goes stable-high now; one Commit exactly 2+DB cycles later.
  task automatic press_and_commit();
    BotaoConfirma = 1'b1;
    for (int n = 0; n <= 2 + DB; n++) begin
      chk("wait_commit", Commit, (n == 2 + DB) ? 1 : 0);
      chk("wait_inibe", Inibe, 0);
      tick();
    end
    m_pc = nxt(m_pc);
    CTRLCLK = 1'b0;
    chk("post_in_addr", EndInstr, m_pc);
    chk("post_in_inibe", Inibe, 1);
    chk("post_in_commit", Commit, 0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    CTRLHalt = 1'b0; CTRLCLK = 1'b0;
    m_pc = 0;
    chk("rst_addr", EndInstr, 0);
    chk("rst_halted", Halted, 0);
    chk("rst_commit", Commit, 0);
    chk("rst_inibe", Inibe, 1);
    chk("rst_ir", Instrucao, 0);
  endtask

  initial begin
    Reset = 1'b1; CTRLDesvio = 2'b00; AlvoImediato = '0; AlvoReg = '0;
    CTRLHalt = 1'b0; CTRLCLK = 1'b0; BotaoConfirma = 1'b0;
    for (int i = 0; i < NPC; i++) mem[i] = $urandom;
    mem[0] = {8'h01, 24'(($urandom))};   // ADD
    mem[1] = {8'h02, 24'(($urandom))};   // SUB
    mem[2] = {8'h01, 24'(($urandom))};   // ADD
    tick();
    do_reset();

    // Sequential ADD, SUB, ADD
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, 0);

    // Branch selection
    run_instr(1, 'h123, 'h2AA, 0, 0);
    run_instr(2, 'h3C1, 'h005, 0, 0);
    run_instr(3, 'h111, 'h222, 0, 0);
    chk("desvio11_target", EndInstr, 'h006);

    // Wrap from the top of the address space
    run_instr(1, 'h3FF, 0, 0, 0);
    run_instr(0, 0, 0, 0, 0);
    chk("wrap_addr", EndInstr, 0);

    // Random branch traffic
    for (int i = 0; i < 30; i++)
      run_instr($urandom_range(0, 3), $urandom_range(0, NPC - 1),
                $urandom_range(0, NPC - 1), 0, 0);

    // IN wait with a bouncing button
    run_instr(0, 0, 0, 0, 1);
    for (int n = 0; n < 4; n++) begin
      BotaoConfirma = (n % 2 == 0);
      chk("bounce_commit", Commit, 0);
      tick();
    end
    press_and_commit();
    BotaoConfirma = 1'b0;
    for (int n = 0; n < 4; n++) run_instr(0, 0, 0, 0, 0);

    // Button already held when WAIT_IN is entered
    BotaoConfirma = 1'b1;
    run_instr(0, 0, 0, 0, 0);
    run_instr(0, 0, 0, 0, 0);
    run_instr(0, 0, 0, 0, 1);
    for (int n = 0; n < 10; n++) begin
      chk("held_commit", Commit, 0);
      tick();
    end
    BotaoConfirma = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk("release_commit", Commit, 0);
      tick();
    end
    press_and_commit();
    BotaoConfirma = 1'b0;
    run_instr(0, 0, 0, 0, 0);

    // Reset in the middle of WAIT_IN, one cycle before the press would land
    run_instr(0, 0, 0, 0, 1);
    BotaoConfirma = 1'b1;
    for (int n = 0; n < 1 + DB; n++) begin
      chk("pre_rst_commit", Commit, 0);
      tick();
    end
    BotaoConfirma = 1'b0;
    do_reset();
    for (int n = 0; n < 3; n++) run_instr(0, 0, 0, 0, 0);
    run_instr(0, 0, 0, 0, 1);
    press_and_commit();
    BotaoConfirma = 1'b0;

    // Halt beats IN; frozen for 25 cycles with presses ignored
    run_instr($urandom_range(0, 3), $urandom_range(0, NPC - 1),
              $urandom_range(0, NPC - 1), 1, 1);
    for (int n = 0; n < 25; n++) begin
      BotaoConfirma = ((n / 8) % 2 == 1);
      chk("halt_halted", Halted, 1);
      chk("halt_inibe", Inibe, 1);
      chk("halt_commit", Commit, 0);
      chk("halt_addr", EndInstr, m_pc);
      tick();
    end
    BotaoConfirma = 1'b0;

    // Reset out of HALT, then normal operation resumes from 0
    do_reset();
    run_instr(0, 0, 0, 0, 0);
    run_instr(0, 0, 0, 0, 0);
    chk("resume_addr", EndInstr, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
